// File: rtl/ring_count_checker.sv
// Monitor for a one-hot ring counter: decodes index, checks one-hot-ness,
// tracks single-step rotation, locks, and counts sequence errors / wraps.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   count_in     ring counter value under check
//   count_vld    sample qualifier
//   clr_cnt      synchronous clear of err_cnt / wrap_cnt
//   index        binary position of last valid one-hot sample
//   onehot_ok    last valid sample had exactly one bit set
//   locked       sequence tracking locked
//   seq_err      pulse: rotation mismatch while locked
//   wrap         pulse: correct rotation through wrap position while locked
//   err_cnt      saturating seq_err count
//   wrap_cnt     modulo-2^16 wrap count
module ring_count_checker #(
  parameter int WIDTH    = 8,
  parameter int IDXW     = 3,
  parameter int DIR      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_vld,
  input  logic             clr_cnt,
  output logic [IDXW-1:0]  index,
  output logic             onehot_ok,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap,
  output logic [7:0]       err_cnt,
  output logic [15:0]      wrap_cnt
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKD
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_n;
  logic [WIDTH-1:0] expect_v;
  logic [7:0]       run;
  logic [7:0]       run_n;
  logic [5:0]       ones;
  logic [IDXW-1:0]  pos;
  logic             is_oh;
  logic             match;
  logic             at_wrap;
  logic             err_n;
  logic             wrap_n;

  always_comb begin
    ones = '0;
    pos  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count_in[i]) begin
        ones = ones + 6'd1;
        pos  = IDXW'(i);
      end
    end
  end

  assign is_oh = (ones == 6'd1);

  generate
    if (DIR == 0) begin : g_left
      assign expect_v = {prev[WIDTH-2:0], prev[WIDTH-1]};
      assign at_wrap  = count_in[0];
    end else begin : g_right
      assign expect_v = {prev[0], prev[WIDTH-1:1]};
      assign at_wrap  = count_in[WIDTH-1];
    end
  endgenerate

  // expect_v is always one-hot once tracking, so match implies is_oh
  assign match = (count_in == expect_v);

  always_comb begin
    state_n = state;
    prev_n  = prev;
    run_n   = run;
    err_n   = 1'b0;
    wrap_n  = 1'b0;
    if (count_vld) begin
      unique case (state)
        SEARCH: begin
          if (is_oh) begin
            prev_n  = count_in;
            run_n   = '0;
            state_n = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            prev_n = count_in;
            run_n  = run + 8'd1;
            if (run_n == LOCK_CNT[7:0])
              state_n = LOCKD;
          end else if (is_oh) begin
            prev_n = count_in;
            run_n  = '0;
          end else begin
            state_n = SEARCH;
          end
        end
        LOCKD: begin
          if (match) begin
            prev_n = count_in;
            wrap_n = at_wrap;
          end else begin
            err_n = 1'b1;
            run_n = '0;
            if (is_oh) begin
              prev_n  = count_in;
              state_n = VERIFY;
            end else begin
              state_n = SEARCH;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      prev      <= '0;
      run       <= '0;
      index     <= '0;
      onehot_ok <= 1'b0;
      locked    <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
    end else begin
      state   <= state_n;
      prev    <= prev_n;
      run     <= run_n;
      locked  <= (state_n == LOCKD);
      seq_err <= err_n;
      wrap    <= wrap_n;
      if (count_vld) begin
        onehot_ok <= is_oh;
        if (is_oh)
          index <= pos;
      end
      // clear beats a same-cycle increment
      if (clr_cnt) begin
        err_cnt  <= '0;
        wrap_cnt <= '0;
      end else begin
        if (err_n && err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
        if (wrap_n)
          wrap_cnt <= wrap_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ring_count_checker.sv
// Randomized + directed bench for ring_count_checker (W=8, left, lock 4).
// Reference model works on bit positions and modular arithmetic.
module tb_ring_count_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] count_in = '0;
  logic       count_vld = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [2:0] index;
  logic       onehot_ok;
  logic       locked;
  logic       seq_err;
  logic       wrap;
  logic [7:0] err_cnt;
  logic [15:0] wrap_cnt;

  int checks = 0;
  int failures = 0;

  ring_count_checker #(
    .WIDTH(8), .IDXW(3), .DIR(0), .LOCK_CNT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .count_in(count_in), .count_vld(count_vld),
    .clr_cnt(clr_cnt), .index(index),
    .onehot_ok(onehot_ok), .locked(locked),
    .seq_err(seq_err), .wrap(wrap),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  // model: mode 0 searching, 1 verifying, 2 locked
  int        m_mode, m_prev, m_run, m_err, m_wcnt;
  logic [2:0] m_index;
  logic      m_ok, m_locked, m_seq, m_wrap;

  task automatic mdl_reset();
    m_mode = 0; m_prev = 0; m_run = 0;
    m_err = 0; m_wcnt = 0; m_index = 0;
    m_ok = 0; m_locked = 0; m_seq = 0; m_wrap = 0;
  endtask

  task automatic mdl_step(input bit v, input logic [7:0] c,
                          input bit cl);
    int  pos;
    bit  oh, hit;
    pos = 0;
    m_seq = 0;
    m_wrap = 0;
    if (v) begin
      oh = ($countones(c) == 1);
      for (int i = 0; i < 8; i++) if (c[i]) pos = i;
      hit = oh && (pos == (m_prev + 1) % 8);
      m_ok = oh;
      if (oh) m_index = pos[2:0];
      if (m_mode == 0) begin
        if (oh) begin m_prev = pos; m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (hit) begin
          m_prev = pos; m_run++;
          if (m_run == 4) m_mode = 2;
        end else if (oh) begin
          m_prev = pos; m_run = 0;
        end else m_mode = 0;
      end else begin
        if (hit) begin
          m_prev = pos;
          if (pos == 0) m_wrap = 1;
        end else begin
          m_seq = 1; m_run = 0;
          if (oh) begin m_prev = pos; m_mode = 1; end
          else m_mode = 0;
        end
      end
    end
    if (cl) begin
      m_err = 0; m_wcnt = 0;
    end else begin
      if (m_seq && m_err < 255) m_err++;
      if (m_wrap) m_wcnt = (m_wcnt + 1) % 65536;
    end
    m_locked = (m_mode == 2);
  endtask

  task automatic step(input bit v, input logic [7:0] c, input bit cl);
    count_vld = v; count_in = c; clr_cnt = cl;
    @(posedge clk); #1;
    mdl_step(v, c, cl);
  endtask

  task automatic do_reset();
    count_vld = 0; clr_cnt = 0; count_in = '0;
    rst_n = 0;
    mdl_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({index, onehot_ok, locked, seq_err, wrap, err_cnt, wrap_cnt}
        !== '0) begin
      failures++;
      $display("FAIL reset: got idx=%0d ok=%b lk=%b se=%b wr=%b ec=%0d wc=%0d exp all 0",
               index, onehot_ok, locked, seq_err, wrap, err_cnt, wrap_cnt);
    end
  endtask

  task automatic test_lock_wrap();
    logic [7:0] v;
    for (int i = 0; i < 5; i++) begin
      v = 8'(1 << i);
      step(1, v, 0);
      checks += 3;
      if (index !== 3'(i)) begin
        failures++;
        $display("FAIL lock_index: got %0d exp %0d", index, i);
      end
      if (onehot_ok !== 1'b1) begin
        failures++;
        $display("FAIL lock_onehot: got %b exp 1", onehot_ok);
      end
      if (locked !== (i == 4)) begin
        failures++;
        $display("FAIL lock_locked step %0d: got %b exp %b", i, locked, i == 4);
      end
    end
    for (int i = 5; i < 10; i++) begin
      v = 8'(1 << (i % 8));
      step(1, v, 0);
      checks += 2;
      if (wrap !== (i == 8)) begin
        failures++;
        $display("FAIL wrap_pulse step %0d: got %b exp %b", i, wrap, i == 8);
      end
      if (locked !== 1'b1) begin
        failures++;
        $display("FAIL wrap_locked: got %b exp 1", locked);
      end
    end
    checks += 2;
    if (wrap_cnt !== 16'd1) begin
      failures++;
      $display("FAIL wrap_cnt: got %0d exp 1", wrap_cnt);
    end
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL wrap_err_cnt: got %0d exp 0", err_cnt);
    end
  endtask

  task automatic test_bad_sample();
    step(1, 8'h06, 0);
    checks += 5;
    if (seq_err !== 1'b1) begin
      failures++; $display("FAIL bad_seq_err: got %b exp 1", seq_err);
    end
    if (err_cnt !== 8'd1) begin
      failures++; $display("FAIL bad_err_cnt: got %0d exp 1", err_cnt);
    end
    if (onehot_ok !== 1'b0) begin
      failures++; $display("FAIL bad_onehot: got %b exp 0", onehot_ok);
    end
    if (index !== 3'd1) begin
      failures++; $display("FAIL bad_index_hold: got %0d exp 1", index);
    end
    if (locked !== 1'b0) begin
      failures++; $display("FAIL bad_unlock: got %b exp 0", locked);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 8'(1 << i), 0);
      checks++;
      if (seq_err !== 1'b0) begin
        failures++; $display("FAIL relock_seq_err: got %b exp 0", seq_err);
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL relock: got %b exp 1", locked);
    end
  endtask

  task automatic test_bad_counter();
    logic [7:0] pat [4];
    pat[0] = 8'h01; pat[1] = 8'h03; pat[2] = 8'h07; pat[3] = 8'h0F;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, pat[i], 0);
      checks += 4;
      if (onehot_ok !== (i == 0)) begin
        failures++;
        $display("FAIL badctr_onehot %0d: got %b exp %b", i, onehot_ok, i == 0);
      end
      if (locked !== 1'b0) begin
        failures++; $display("FAIL badctr_locked: got %b exp 0", locked);
      end
      if (err_cnt !== 8'd0) begin
        failures++; $display("FAIL badctr_err_cnt: got %0d exp 0", err_cnt);
      end
      if (index !== 3'd0) begin
        failures++; $display("FAIL badctr_index: got %0d exp 0", index);
      end
    end
  endtask

  task automatic test_vld_gaps();
    for (int i = 0; i < 5; i++) step(1, 8'(1 << i), 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'($urandom), 0);
      checks += 3;
      if (seq_err !== 1'b0) begin
        failures++; $display("FAIL gap_seq_err: got %b exp 0", seq_err);
      end
      if (locked !== 1'b1) begin
        failures++; $display("FAIL gap_locked: got %b exp 1", locked);
      end
      if (index !== 3'd4) begin
        failures++; $display("FAIL gap_index: got %0d exp 4", index);
      end
    end
    step(1, 8'h20, 0);
    checks += 2;
    if (seq_err !== 1'b0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL gap_resume: got se=%b lk=%b exp se=0 lk=1", seq_err, locked);
    end
    if (index !== 3'd5) begin
      failures++; $display("FAIL gap_resume_index: got %0d exp 5", index);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'(1 << i), 0);
    for (int k = 0; k < 300; k++) begin
      step(1, 8'h00, 0);
      checks++;
      if (seq_err !== 1'b1 || err_cnt !== m_err[7:0]) begin
        failures++;
        $display("FAIL sat_step %0d: got se=%b ec=%0d exp se=1 ec=%0d",
                 k, seq_err, err_cnt, m_err);
      end
      for (int i = 0; i < 5; i++) step(1, 8'(1 << i), 0);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++; $display("FAIL sat_final: got %0h exp ff", err_cnt);
    end
  endtask

  task automatic test_clr_collision();
    step(1, 8'h00, 1);
    checks += 3;
    if (seq_err !== 1'b1) begin
      failures++; $display("FAIL clr_pulse: got %b exp 1", seq_err);
    end
    if (err_cnt !== 8'd0) begin
      failures++; $display("FAIL clr_err_cnt: got %0d exp 0", err_cnt);
    end
    if (locked !== 1'b0) begin
      failures++; $display("FAIL clr_locked: got %b exp 0", locked);
    end
    step(0, 8'h00, 0);
  endtask

  task automatic test_random();
    bit         v, cl;
    int         r;
    logic [7:0] c;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom % 8) != 0;
      cl = ($urandom % 64) == 0;
      r  = $urandom % 10;
      if (r < 7)       c = 8'(1 << ((m_prev + 1) % 8));
      else if (r == 7) c = 8'(1 << ($urandom % 8));
      else if (r == 8) c = 8'(1 << m_prev);
      else             c = 8'($urandom);
      step(v, c, cl);
      checks += 7;
      if (index !== m_index) begin
        failures++; $display("FAIL rnd_index @%0d: got %0d exp %0d", n, index, m_index);
      end
      if (onehot_ok !== m_ok) begin
        failures++; $display("FAIL rnd_onehot @%0d: got %b exp %b", n, onehot_ok, m_ok);
      end
      if (locked !== m_locked) begin
        failures++; $display("FAIL rnd_locked @%0d: got %b exp %b", n, locked, m_locked);
      end
      if (seq_err !== m_seq) begin
        failures++; $display("FAIL rnd_seq_err @%0d: got %b exp %b", n, seq_err, m_seq);
      end
      if (wrap !== m_wrap) begin
        failures++; $display("FAIL rnd_wrap @%0d: got %b exp %b", n, wrap, m_wrap);
      end
      if (err_cnt !== m_err[7:0]) begin
        failures++; $display("FAIL rnd_err_cnt @%0d: got %0d exp %0d", n, err_cnt, m_err);
      end
      if (wrap_cnt !== m_wcnt[15:0]) begin
        failures++; $display("FAIL rnd_wrap_cnt @%0d: got %0d exp %0d", n, wrap_cnt, m_wcnt);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) step(1, 8'(1 << (i % 8)), 0);
    step(1, 8'h00, 0);
    checks++;
    if (err_cnt !== m_err[7:0] || wrap_cnt !== m_wcnt[15:0]) begin
      failures++;
      $display("FAIL arst_pre: got ec=%0d wc=%0d exp ec=%0d wc=%0d",
               err_cnt, wrap_cnt, m_err, m_wcnt);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({index, onehot_ok, locked, seq_err, wrap, err_cnt, wrap_cnt}
        !== '0) begin
      failures++;
      $display("FAIL arst_now: got idx=%0d ok=%b lk=%b se=%b wr=%b ec=%0d wc=%0d exp all 0",
               index, onehot_ok, locked, seq_err, wrap, err_cnt, wrap_cnt);
    end
    mdl_reset();
    count_vld = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'(1 << i), 0);
      checks++;
      if (locked !== (i == 4)) begin
        failures++;
        $display("FAIL arst_relock %0d: got %b exp %b", i, locked, i == 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_wrap();
    test_bad_sample();
    test_bad_counter();
    test_vld_gaps();
    test_saturation();
    test_vld_gaps();
    test_clr_collision();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
